// File: rtl/crc_frame_pkg.sv
// CRC frame arbiter shared types: FSM state encoding and
// default CRC/word widths used by the arbiter and its CRC step.
package crc_frame_pkg;

  localparam int CRC_WIDTH_DEF = 16;
  localparam int DWIDTH_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/crc_word_step.sv
// One-word CRC update: optional per-byte reflect, then DWIDTH bits
// fed MSB-first. Ports: crc/data/poly/refIn in, nextCrc out.
module crc_word_step
  import crc_frame_pkg::*;
#(
  parameter int CRC_WIDTH = CRC_WIDTH_DEF,
  parameter int DWIDTH    = DWIDTH_DEF
) (
  input  logic [CRC_WIDTH-1:0] crc,
  input  logic [DWIDTH-1:0]    data,
  input  logic [CRC_WIDTH-1:0] poly,
  input  logic                 refIn,
  output logic [CRC_WIDTH-1:0] nextCrc
);

  logic [DWIDTH-1:0]    d;
  logic [CRC_WIDTH-1:0] c;
  logic                 fb;

  always_comb begin
    d  = data;
    c  = crc;
    fb = 1'b0;
    if (refIn) begin
      for (int b = 0; b < DWIDTH / 8; b++) begin
        for (int i = 0; i < 8; i++) begin
          d[b*8+i] = data[b*8+7-i];
        end
      end
    end
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ d[i];
      c  = (c << 1) ^ (fb ? poly : '0);
    end
    nextCrc = c;
  end

endmodule

// File: rtl/crc_frame_arbiter.sv
// Round-robin frame arbiter computing one CRC per granted frame.
// Ports: clk, rst (sync, active-high); reqValid/reqData/reqLast in,
// reqReady out; CRC config in (genPoly, initValue, finalXorValue,
// refInEn, refOutEn); crcValid/crcOut/crcId out, crcReady in;
// errAbort out. Define CRC_FRAME_TIMEOUT_EN to enable the RUN stall
// timeout; otherwise errAbort is tied low and RUN waits forever.
module crc_frame_arbiter
  import crc_frame_pkg::*;
#(
  parameter int CRC_WIDTH   = CRC_WIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        reqValid,
  input  logic [NREQ*DWIDTH-1:0] reqData,
  input  logic [NREQ-1:0]        reqLast,
  output logic [NREQ-1:0]        reqReady,
  input  logic [CRC_WIDTH-1:0]   genPoly,
  input  logic [CRC_WIDTH-1:0]   initValue,
  input  logic [CRC_WIDTH-1:0]   finalXorValue,
  input  logic                   refInEn,
  input  logic                   refOutEn,
  output logic                   crcValid,
  output logic [CRC_WIDTH-1:0]   crcOut,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] crcId,
  input  logic                   crcReady,
  output logic                   errAbort
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e               state_q;
  logic [IDW-1:0]       rr_q;
  logic [IDW-1:0]       grant_q;
  logic [CRC_WIDTH-1:0] crcSeq_q;
  logic [CRC_WIDTH-1:0] crcSeq_d;
  logic [CRC_WIDTH-1:0] poly_q;
  logic [CRC_WIDTH-1:0] xor_q;
  logic                 refIn_q;
  logic                 refOut_q;
  logic [NREQ-1:0]      reqReady_q;
  logic                 crcValid_q;
  logic [CRC_WIDTH-1:0] crcOut_q;

  logic [IDW-1:0]       pick;
  logic [IDW-1:0]       rrNext;
  logic                 found;
  int                   idx;
  logic [DWIDTH-1:0]    wordData;
  logic                 accept;

  function automatic logic [CRC_WIDTH-1:0] rev(
    input logic [CRC_WIDTH-1:0] v
  );
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
    return r;
  endfunction

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!found && reqValid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign rrNext   = (int'(pick) == NREQ - 1) ? '0 : pick + IDW'(1);
  assign wordData = reqData[int'(grant_q)*DWIDTH +: DWIDTH];
  assign accept   = (state_q == RUN) && reqValid[grant_q];

  crc_word_step #(
    .CRC_WIDTH(CRC_WIDTH),
    .DWIDTH   (DWIDTH)
  ) u_step (
    .crc    (crcSeq_q),
    .data   (wordData),
    .poly   (poly_q),
    .refIn  (refIn_q),
    .nextCrc(crcSeq_d)
  );

`ifdef CRC_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall_q;
  logic          errAbort_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      crcSeq_q   <= '0;
      poly_q     <= '0;
      xor_q      <= '0;
      refIn_q    <= 1'b0;
      refOut_q   <= 1'b0;
      reqReady_q <= '0;
      crcValid_q <= 1'b0;
      crcOut_q   <= '0;
`ifdef CRC_FRAME_TIMEOUT_EN
      stall_q    <= '0;
      errAbort_q <= 1'b0;
`endif
    end else begin
`ifdef CRC_FRAME_TIMEOUT_EN
      errAbort_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q    <= pick;
            rr_q       <= rrNext;
            crcSeq_q   <= initValue;
            poly_q     <= genPoly;
            xor_q      <= finalXorValue;
            refIn_q    <= refInEn;
            refOut_q   <= refOutEn;
            reqReady_q <= NREQ'(1) << pick;
            state_q    <= RUN;
`ifdef CRC_FRAME_TIMEOUT_EN
            stall_q    <= '0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            crcSeq_q <= crcSeq_d;
`ifdef CRC_FRAME_TIMEOUT_EN
            stall_q  <= '0;
`endif
            if (reqLast[grant_q]) begin
              reqReady_q <= '0;
              crcValid_q <= 1'b1;
              crcOut_q   <= (refOut_q ? rev(crcSeq_d) : crcSeq_d) ^ xor_q;
              state_q    <= DONE;
            end
          end
`ifdef CRC_FRAME_TIMEOUT_EN
          // Abort on the edge where the stall count reaches the limit.
          else if (stall_q == TW'(TIMEOUT_CYC - 1)) begin
            errAbort_q <= 1'b1;
            reqReady_q <= '0;
            state_q    <= IDLE;
          end else begin
            stall_q <= stall_q + TW'(1);
          end
`endif
        end
        DONE: begin
          if (crcReady) begin
            crcValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reqReady = reqReady_q;
  assign crcValid = crcValid_q;
  assign crcOut   = crcOut_q;
  assign crcId    = grant_q;
`ifdef CRC_FRAME_TIMEOUT_EN
  assign errAbort = errAbort_q;
`else
  assign errAbort = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Self-checking bench for crc_frame_arbiter (DWIDTH=8, NREQ=2,
// TIMEOUT_CYC=8); timeout sequence runs when CRC_FRAME_TIMEOUT_EN is set.
module tb_crc_frame_arbiter;

  localparam int CW = 16;
  localparam int DW = 8;
  localparam int NR = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   reqValid;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]   reqLast;
  logic [NR-1:0]   reqReady;
  logic [CW-1:0]   genPoly;
  logic [CW-1:0]   initValue;
  logic [CW-1:0]   finalXorValue;
  logic            refInEn;
  logic            refOutEn;
  logic            crcValid;
  logic [CW-1:0]   crcOut;
  logic [0:0]      crcId;
  logic            crcReady;
  logic            errAbort;

  crc_frame_arbiter #(
    .CRC_WIDTH  (CW),
    .DWIDTH     (DW),
    .NREQ       (NR),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqData      (reqData),
    .reqLast      (reqLast),
    .reqReady     (reqReady),
    .genPoly      (genPoly),
    .initValue    (initValue),
    .finalXorValue(finalXorValue),
    .refInEn      (refInEn),
    .refOutEn     (refOutEn),
    .crcValid     (crcValid),
    .crcOut       (crcOut),
    .crcId        (crcId),
    .crcReady     (crcReady),
    .errAbort     (errAbort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int         validCycles = 0;
  logic [0:0] resId[$];
  logic [15:0] resCrc[$];
  int         wordOwner[$];

  always @(posedge clk) begin
    if (!rst && crcValid) validCycles++;
    if (!rst && crcValid && crcReady) begin
      resId.push_back(crcId);
      resCrc.push_back(crcOut);
    end
    for (int i = 0; i < NR; i++)
      if (!rst && reqValid[i] && reqReady[i]) wordOwner.push_back(i);
  end

  logic [7:0] msg[9];

  typedef struct {
    logic        single;
    logic [15:0] poly;
    logic [15:0] init;
    logic [15:0] xr;
    logic        ri;
    logic        ro;
    int          r;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[5];

  task automatic cfg(input logic [15:0] p, input logic [15:0] i,
                     input logic [15:0] x, input logic ri,
                     input logic ro);
    genPoly = p;
    initValue = i;
    finalXorValue = x;
    refInEn = ri;
    refOutEn = ro;
  endtask

  // Present one word and return #1 after the edge that accepts it.
  task automatic send_word(input int r, input logic [7:0] d,
                           input logic last);
    int n;
    n = 0;
    reqValid[r] = 1'b1;
    reqData[r*DW +: DW] = d;
    reqLast[r] = last;
    @(negedge clk);
    while (!reqReady[r] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, reqReady[r]}, 32'd1);
    if (last) chk("valid_before_last", {31'd0, crcValid}, 32'd0);
    @(posedge clk);
    #1;
    reqValid[r] = 1'b0;
    reqLast[r] = 1'b0;
  endtask

  task automatic send_msg(input int r);
    for (int i = 0; i < 9; i++) send_word(r, msg[i], i == 8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    reqValid = '0;
    reqLast = '0;
    reqData = '0;
    crcReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    int vc;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
            8'h36, 8'h37, 8'h38, 8'h39};
    vt[0] = '{1'b0, 16'h1021, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0, 16'h29B1};
    vt[1] = '{1'b0, 16'h8005, 16'h0000, 16'h0000, 1'b1, 1'b1, 1, 16'hBB3D};
    vt[2] = '{1'b0, 16'h1021, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, 16'h2189};
    vt[3] = '{1'b1, 16'h1021, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1, 16'hEFDE};
    vt[4] = '{1'b1, 16'h1021, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 0, 16'h7BF7};

    cfg(16'h1021, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    do_reset();
    @(negedge clk);
    chk("rst_valid", {31'd0, crcValid}, 32'd0);
    chk("rst_out", {16'd0, crcOut}, 32'd0);
    chk("rst_id", {31'd0, crcId}, 32'd0);
    chk("rst_ready", {30'd0, reqReady}, 32'd0);
    chk("rst_abort", {31'd0, errAbort}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      cfg(vt[v].poly, vt[v].init, vt[v].xr, vt[v].ri, vt[v].ro);
      if (vt[v].single) send_word(vt[v].r, 8'h01, 1'b1);
      else send_msg(vt[v].r);
      chk("vec_valid", {31'd0, crcValid}, 32'd1);
      chk("vec_crc", {16'd0, crcOut}, {16'd0, vt[v].exp});
      chk("vec_id", {31'd0, crcId}, vt[v].r);
      @(posedge clk);
      #1;
      chk("vec_drop", {31'd0, crcValid}, 32'd0);
    end

    cfg(16'h1021, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    crcReady = 1'b0;
    send_word(0, msg[0], 1'b0);
    cfg(16'hDEAD, 16'h1234, 16'h5555, 1'b1, 1'b1);
    for (int i = 1; i < 9; i++) send_word(0, msg[i], i == 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, crcValid}, 32'd1);
      chk("hold_crc", {16'd0, crcOut}, 32'h29B1);
      chk("hold_id", {31'd0, crcId}, 32'd0);
    end
    base = resId.size();
    crcReady = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_drop", {31'd0, crcValid}, 32'd0);
    repeat (3) @(posedge clk);
    chk("hold_xfers", resId.size() - base, 32'd1);
    if (resCrc.size() > base) chk("hold_xcrc", {16'd0, resCrc[base]}, 32'h29B1);

    do_reset();
    cfg(16'h1021, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    base = resId.size();
    wordOwner.delete();
    fork
      begin
        for (int f = 0; f < 2; f++)
          for (int w = 0; w < 3; w++) send_word(0, 8'(f * 4 + w), w == 2);
      end
      begin
        for (int f = 0; f < 2; f++)
          for (int w = 0; w < 3; w++) send_word(1, 8'(16 + f * 4 + w), w == 2);
      end
    join
    repeat (3) @(posedge clk);
    chk("rr_nres", resId.size() - base, 32'd4);
    for (int i = 0; i < 4; i++)
      if (resId.size() > base + i)
        chk("rr_order", {31'd0, resId[base+i]}, i % 2);
    chk("rr_nwords", wordOwner.size(), 32'd12);
    for (int i = 0; i < 12; i++)
      if (wordOwner.size() > i) chk("rr_words", wordOwner[i], (i / 3) % 2);

    do_reset();
    cfg(16'h1021, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    vc = validCycles;
    send_word(0, msg[0], 1'b0);
    send_word(0, msg[1], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", {30'd0, reqReady}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_novalid", validCycles - vc, 32'd0);
    base = resId.size();
    fork
      send_msg(0);
      send_word(1, 8'h01, 1'b1);
    join
    repeat (3) @(posedge clk);
    chk("mrst_nres", resId.size() - base, 32'd2);
    if (resId.size() > base) begin
      chk("mrst_first_id", {31'd0, resId[base]}, 32'd0);
      chk("mrst_first_crc", {16'd0, resCrc[base]}, 32'h29B1);
    end
    if (resId.size() > base + 1)
      chk("mrst_second_id", {31'd0, resId[base+1]}, 32'd1);

`ifdef CRC_FRAME_TIMEOUT_EN
    do_reset();
    cfg(16'h1021, 16'h0000, 16'h0000, 1'b0, 1'b0);
    vc = validCycles;
    send_word(1, 8'h11, 1'b0);
    send_word(1, 8'h22, 1'b0);
    reqValid[0] = 1'b1;
    reqData[7:0] = 8'h01;
    reqLast[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        chk("to_pulse", {31'd0, errAbort}, 32'd1);
        chk("to_id", {31'd0, crcId}, 32'd1);
        chk("to_novalid", {31'd0, crcValid}, 32'd0);
      end else begin
        chk("to_quiet", {31'd0, errAbort}, 32'd0);
      end
    end
    chk("to_nocrc", validCycles - vc, 32'd0);
    send_word(0, 8'h01, 1'b1);
    chk("to_next_valid", {31'd0, crcValid}, 32'd1);
    chk("to_next_id", {31'd0, crcId}, 32'd0);
    chk("to_next_crc", {16'd0, crcOut}, 32'h1021);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
